// File: rtl/vfr_unpack_line_sequencer.sv
// Frame reader unpack sequencer: sizes a line in memory words, issues one read per line,
// counts unpacked pixels and pulses the unpacker clear at each line end.
// state | meaning
// IDLE  | waiting for go
// CALC  | words = ceil(width*DATA_WIDTH_OUT / DATA_WIDTH_IN), once per frame
// CMD   | line read command offered to the read master
// LINE  | counting pixels out of the unpacker
// CLR   | discard partial-word padding, advance to next line
// DONE  | frame complete pulse
// ABORT | discard pulse after stop
module vfr_unpack_line_sequencer #(
  parameter int DATA_WIDTH_IN  = 128,
  parameter int DATA_WIDTH_OUT = 24,
  parameter int ADDR_WIDTH     = 32,
  parameter int DIM_WIDTH      = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  go,
  input  logic                  stop,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [DIM_WIDTH-1:0]  line_stride,
  input  logic [DIM_WIDTH-1:0]  width,
  input  logic [DIM_WIDTH-1:0]  height,
  output logic                  cmd_valid,
  input  logic                  cmd_ready,
  output logic [ADDR_WIDTH-1:0] cmd_addr,
  output logic [DIM_WIDTH-1:0]  cmd_words,
  input  logic                  pix_write,
  output logic                  clear,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  spurious
);

  // acc may overshoot bits by up to one memory word, hence the extra headroom
  localparam int ACC_W = DIM_WIDTH + $clog2(DATA_WIDTH_OUT) + $clog2(DATA_WIDTH_IN) + 2;

  typedef enum logic [2:0] {
    S_IDLE, S_CALC, S_CMD, S_LINE, S_CLR, S_DONE, S_ABORT
  } state_t;

  state_t                state_q, state_d;
  logic [DIM_WIDTH-1:0]  stride_q, stride_d;
  logic [DIM_WIDTH-1:0]  width_q, width_d;
  logic [DIM_WIDTH-1:0]  height_q, height_d;
  logic [ACC_W-1:0]      bits_q, bits_d;
  logic [ACC_W-1:0]      acc_q, acc_d;
  logic [DIM_WIDTH-1:0]  words_q, words_d;
  logic [ADDR_WIDTH-1:0] line_addr_q, line_addr_d;
  logic [DIM_WIDTH-1:0]  line_cnt_q, line_cnt_d;
  logic [DIM_WIDTH-1:0]  pix_cnt_q, pix_cnt_d;
  logic                  spurious_q, spurious_d;

  always_comb begin
    state_d     = state_q;
    stride_d    = stride_q;
    width_d     = width_q;
    height_d    = height_q;
    bits_d      = bits_q;
    acc_d       = acc_q;
    words_d     = words_q;
    line_addr_d = line_addr_q;
    line_cnt_d  = line_cnt_q;
    pix_cnt_d   = pix_cnt_q;
    spurious_d  = spurious_q | (pix_write && (state_q != S_LINE));

    case (state_q)
      S_IDLE: begin
        if (go) begin
          stride_d    = line_stride;
          width_d     = width;
          height_d    = height;
          bits_d      = ACC_W'(width) * ACC_W'(DATA_WIDTH_OUT);
          acc_d       = '0;
          words_d     = '0;
          line_addr_d = base_addr;
          line_cnt_d  = '0;
          spurious_d  = 1'b0;
          state_d     = ((width == '0) || (height == '0)) ? S_DONE : S_CALC;
        end
      end
      S_CALC: begin
        if (acc_q < bits_q) begin
          acc_d   = acc_q + ACC_W'(DATA_WIDTH_IN);
          words_d = words_q + DIM_WIDTH'(1);
        end else begin
          state_d = S_CMD;
        end
      end
      S_CMD: begin
        if (cmd_ready) begin
          pix_cnt_d = '0;
          state_d   = S_LINE;
        end
      end
      S_LINE: begin
        if (pix_write) begin
          if (pix_cnt_q == width_q - DIM_WIDTH'(1)) state_d = S_CLR;
          else pix_cnt_d = pix_cnt_q + DIM_WIDTH'(1);
        end
      end
      S_CLR: begin
        line_cnt_d  = line_cnt_q + DIM_WIDTH'(1);
        line_addr_d = line_addr_q + ADDR_WIDTH'(stride_q);
        state_d     = (line_cnt_q == height_q - DIM_WIDTH'(1)) ? S_DONE : S_CMD;
      end
      S_DONE:  state_d = S_IDLE;
      S_ABORT: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // ABORT is excluded so a held stop still yields a single clear pulse
    if (stop && (state_q != S_IDLE) && (state_q != S_DONE) && (state_q != S_ABORT)) begin
      state_d = S_ABORT;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      stride_q    <= '0;
      width_q     <= '0;
      height_q    <= '0;
      bits_q      <= '0;
      acc_q       <= '0;
      words_q     <= '0;
      line_addr_q <= '0;
      line_cnt_q  <= '0;
      pix_cnt_q   <= '0;
      spurious_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      stride_q    <= stride_d;
      width_q     <= width_d;
      height_q    <= height_d;
      bits_q      <= bits_d;
      acc_q       <= acc_d;
      words_q     <= words_d;
      line_addr_q <= line_addr_d;
      line_cnt_q  <= line_cnt_d;
      pix_cnt_q   <= pix_cnt_d;
      spurious_q  <= spurious_d;
    end
  end

  assign cmd_valid  = (state_q == S_CMD);
  assign cmd_addr   = line_addr_q;
  assign cmd_words  = words_q;
  assign clear      = (state_q == S_CLR) || (state_q == S_ABORT);
  assign busy       = (state_q != S_IDLE);
  assign frame_done = (state_q == S_DONE);
  assign spurious   = spurious_q;

endmodule

// File: tb/tb_vfr_unpack_line_sequencer.sv
// Directed bench for vfr_unpack_line_sequencer: a per-cycle vector table followed by
// hand-written sequences for multi-line frames, back-pressure, abort and reset.
module tb_vfr_unpack_line_sequencer;

  logic        clock;
  logic        reset;
  logic        go;
  logic        stop;
  logic [31:0] base_addr;
  logic [15:0] line_stride;
  logic [15:0] width;
  logic [15:0] height;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_addr;
  logic [15:0] cmd_words;
  logic        pix_write;
  logic        clear;
  logic        busy;
  logic        frame_done;
  logic        spurious;

  int n_checks = 0;
  int n_fail   = 0;

  vfr_unpack_line_sequencer #(
    .DATA_WIDTH_IN(128), .DATA_WIDTH_OUT(24), .ADDR_WIDTH(32), .DIM_WIDTH(16)
  ) dut (
    .clock(clock), .reset(reset), .go(go), .stop(stop),
    .base_addr(base_addr), .line_stride(line_stride), .width(width), .height(height),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_words(cmd_words),
    .pix_write(pix_write), .clear(clear), .busy(busy), .frame_done(frame_done),
    .spurious(spurious)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    logic [3:0] in_v;   // {go, stop, cmd_ready, pix_write}
    logic [4:0] exp_v;  // {cmd_valid, clear, busy, frame_done, spurious}
  } vec_t;

  vec_t tbl[16];

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_cmd();
    int n = 0;
    while (!cmd_valid && n < 64) begin
      step();
      n++;
    end
    check("cmd_valid_timeout", cmd_valid, 1'b1);
  endtask

  // Handshake one command, then stream npix pixels and expect the clear right after the last.
  task automatic run_line(input logic [31:0] exp_addr, input logic [15:0] exp_words, input int npix);
    wait_cmd();
    check("cmd_addr", cmd_addr, exp_addr);
    check("cmd_words", cmd_words, exp_words);
    cmd_ready = 1'b1;
    step();
    cmd_ready = 1'b0;
    check("cmd_valid_after_accept", cmd_valid, 1'b0);
    for (int i = 0; i < npix; i++) begin
      pix_write = 1'b1;
      step();
      if (i < npix - 1) check("clear_early", clear, 1'b0);
    end
    pix_write = 1'b0;
    check("clear_line_end", clear, 1'b1);
    check("frame_done_at_clear", frame_done, 1'b0);
    step();
    check("clear_one_cycle", clear, 1'b0);
  endtask

  task automatic start_frame(input logic [31:0] b, input logic [15:0] s,
                             input logic [15:0] w, input logic [15:0] h);
    base_addr = b; line_stride = s; width = w; height = h;
    go = 1'b1;
    step();
    go = 1'b0;
  endtask

  initial begin
    reset = 1'b1; go = 1'b0; stop = 1'b0; cmd_ready = 1'b0; pix_write = 1'b0;
    base_addr = 32'h2000; line_stride = 16'h0010; width = 16'd6; height = 16'd1;
    step();
    step();
    check("rst_outputs", {cmd_valid, clear, busy, frame_done, spurious}, 5'b0);
    check("rst_cmd_addr", cmd_addr, 32'h0);
    check("rst_cmd_words", cmd_words, 16'h0);
    reset = 1'b0;

    // width=6 height=1: 144 bits -> 2 words, CALC for 3 cycles
    tbl[0]  = '{4'b1000, 5'b00100};
    tbl[1]  = '{4'b0000, 5'b00100};
    tbl[2]  = '{4'b0000, 5'b00100};
    tbl[3]  = '{4'b0000, 5'b10100};
    tbl[4]  = '{4'b0010, 5'b00100};
    tbl[5]  = '{4'b0001, 5'b00100};
    tbl[6]  = '{4'b0001, 5'b00100};
    tbl[7]  = '{4'b0001, 5'b00100};
    tbl[8]  = '{4'b0001, 5'b00100};
    tbl[9]  = '{4'b0001, 5'b00100};
    tbl[10] = '{4'b0001, 5'b01100};
    tbl[11] = '{4'b0000, 5'b00110};
    tbl[12] = '{4'b0000, 5'b00000};
    tbl[13] = '{4'b0001, 5'b00001};
    tbl[14] = '{4'b0000, 5'b00001};
    tbl[15] = '{4'b0100, 5'b00001};

    for (int i = 0; i < 16; i++) begin
      {go, stop, cmd_ready, pix_write} = tbl[i].in_v;
      step();
      check($sformatf("vec%0d_outputs", i), {cmd_valid, clear, busy, frame_done, spurious},
            tbl[i].exp_v);
      if (tbl[i].exp_v[4]) begin
        check($sformatf("vec%0d_cmd_addr", i), cmd_addr, 32'h2000);
        check($sformatf("vec%0d_cmd_words", i), cmd_words, 16'd2);
      end
    end
    {go, stop, cmd_ready, pix_write} = 4'b0000;

    // Two-line frame; the accepted go also clears the sticky spurious flag
    begin
      int n;
      start_frame(32'h1000, 16'h0040, 16'd16, 16'd2);
      check("go_clears_spurious", spurious, 1'b0);
      n = 0;
      while (!cmd_valid && n < 50) begin
        n++;
        step();
      end
      check("calc_cycles", n, 4);
      run_line(32'h1000, 16'd3, 16);
      check("no_done_after_line0", frame_done, 1'b0);
      run_line(32'h1040, 16'd3, 16);
      check("frame_done_2line", frame_done, 1'b1);
      step();
      check("frame_done_one_cycle", frame_done, 1'b0);
      check("busy_after_frame", busy, 1'b0);
    end

    // Back-pressure: command must hold steady until ready
    start_frame(32'h3000, 16'h0010, 16'd6, 16'd1);
    wait_cmd();
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_cmd_valid", cmd_valid, 1'b1);
      check("bp_cmd_addr", cmd_addr, 32'h3000);
      check("bp_cmd_words", cmd_words, 16'd2);
    end
    cmd_ready = 1'b1;
    step();
    cmd_ready = 1'b0;
    check("bp_line_entered", cmd_valid, 1'b0);
    for (int i = 0; i < 5; i++) begin
      pix_write = 1'b1;
      step();
    end
    // last pixel together with stop: abort wins, no frame_done
    stop = 1'b1;
    step();
    stop = 1'b0; pix_write = 1'b0;
    check("lastpix_stop_clear", clear, 1'b1);
    check("lastpix_stop_busy", busy, 1'b1);
    check("lastpix_stop_no_done", frame_done, 1'b0);
    step();
    check("lastpix_stop_idle", {busy, clear, frame_done}, 3'b000);

    // Zero width goes straight to DONE
    start_frame(32'h5000, 16'h0010, 16'd0, 16'd4);
    check("w0_done", {cmd_valid, clear, busy, frame_done}, 4'b0011);
    step();
    check("w0_idle", {cmd_valid, clear, busy, frame_done}, 4'b0000);

    // Abort after 7 of 16 pixels on line 0, then restart from base
    start_frame(32'h1000, 16'h0040, 16'd16, 16'd2);
    wait_cmd();
    cmd_ready = 1'b1;
    step();
    cmd_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      pix_write = 1'b1;
      step();
    end
    pix_write = 1'b0;
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("abort_clear", clear, 1'b1);
    check("abort_no_done", frame_done, 1'b0);
    step();
    check("abort_idle", {busy, clear, frame_done}, 3'b000);
    start_frame(32'h1000, 16'h0040, 16'd16, 16'd2);
    wait_cmd();
    check("restart_addr", cmd_addr, 32'h1000);
    check("restart_words", cmd_words, 16'd3);

    // Stop while a command is offered and accepted in the same cycle
    cmd_ready = 1'b1; stop = 1'b1;
    step();
    cmd_ready = 1'b0; stop = 1'b0;
    check("cmd_stop_valid_drop", cmd_valid, 1'b0);
    check("cmd_stop_clear", clear, 1'b1);
    step();
    check("cmd_stop_idle", busy, 1'b0);

    // Synchronous reset in LINE, with spurious set beforehand
    start_frame(32'h1000, 16'h0040, 16'd16, 16'd2);
    pix_write = 1'b1;
    step();
    pix_write = 1'b0;
    check("spurious_in_calc", spurious, 1'b1);
    wait_cmd();
    cmd_ready = 1'b1;
    step();
    cmd_ready = 1'b0;
    pix_write = 1'b1;
    step();
    step();
    pix_write = 1'b0;
    reset = 1'b1;
    step();
    check("rst_line_outputs", {cmd_valid, clear, busy, frame_done, spurious}, 5'b0);
    check("rst_line_addr", cmd_addr, 32'h0);
    check("rst_line_words", cmd_words, 16'h0);
    reset = 1'b0;
    step();
    check("rst_line_no_clear", {clear, busy}, 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
